// File: rtl/fsm_ring_ctrl.sv
// Ring-ordered Moore controller: advance/retreat/restart commands, dwell-timer auto-advance, restart-state occupancy count.
// One-edge command latency; no backpressure (en gates commands and dwell only).
module fsm_ring_ctrl #(
  parameter int NUM_STATES  = 4,
  parameter int RESET_STATE = 1,
  parameter int TIMEOUT     = 8,
  parameter int COUNT_WIDTH = 8,
  parameter bit SATURATE    = 1'b1,
  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             in,
  output logic [NUM_STATES-1:0]  out,
  output logic [SW-1:0]          state,
  output logic [COUNT_WIDTH-1:0] dwell,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,
    CMD_ADVANCE = 2'd1,
    CMD_RETREAT = 2'd2,
    CMD_RESTART = 2'd3
  } cmd_e;

  localparam logic [SW-1:0]          RST_ST   = SW'(RESET_STATE);
  localparam logic [SW-1:0]          LAST_ST  = SW'(NUM_STATES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] TO_LAST  = COUNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit                     TO_EN    = (TIMEOUT != 0);
  localparam logic [NUM_STATES-1:0]  ONE_HOT0 = NUM_STATES'(1);

  logic [SW-1:0]          state_q;
  logic [COUNT_WIDTH-1:0] dwell_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   timeout_q;

  logic [SW-1:0] adv_st;
  logic [SW-1:0] ret_st;
  logic [SW-1:0] nxt_st;
  logic          take;
  logic          by_timeout;

  assign adv_st = (state_q == LAST_ST) ? '0 : state_q + SW'(1);
  assign ret_st = (state_q == '0) ? LAST_ST : state_q - SW'(1);

  // Commands outrank the dwell timer; a restart counts as a transition even in RESET_STATE.
  always_comb begin
    nxt_st     = state_q;
    take       = 1'b0;
    by_timeout = 1'b0;
    case (cmd_e'(in))
      CMD_RESTART: begin
        nxt_st = RST_ST;
        take   = 1'b1;
      end
      CMD_ADVANCE: begin
        nxt_st = adv_st;
        take   = 1'b1;
      end
      CMD_RETREAT: begin
        nxt_st = ret_st;
        take   = 1'b1;
      end
      default: begin
        if (TO_EN && (dwell_q == TO_LAST)) begin
          nxt_st     = adv_st;
          take       = 1'b1;
          by_timeout = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_ST;
      dwell_q   <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Occupancy follows the registered state, independent of en.
      if (state_q == RST_ST) begin
        if (!(SATURATE && (count_q == CNT_MAX))) begin
          count_q <= count_q + COUNT_WIDTH'(1);
        end
      end
      timeout_q <= 1'b0;
      if (en) begin
        if (take) begin
          state_q   <= nxt_st;
          dwell_q   <= '0;
          timeout_q <= by_timeout;
        end else if (dwell_q != CNT_MAX) begin
          dwell_q <= dwell_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign out     = ONE_HOT0 << state_q;
  assign state   = state_q;
  assign dwell   = dwell_q;
  assign count   = count_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_fsm_ring_ctrl.sv
// Scoreboard bench for fsm_ring_ctrl: directed stimulus pushes hand-computed expectations, a monitor checks them.
module tb_fsm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] in;

  logic [3:0] out0, out1, out2;
  logic [1:0] st0, st1, st2;
  logic [7:0] dw0, dw1, dw2;
  logic [7:0] cn0, cn1, cn2;
  logic       to0, to1, to2;

  always #5 clk = ~clk;

  fsm_ring_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out0), .state(st0), .dwell(dw0), .count(cn0), .timeout(to0)
  );

  // Timer disabled, saturating counter.
  fsm_ring_ctrl #(.TIMEOUT(0)) u_dut_t0 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out1), .state(st1), .dwell(dw1), .count(cn1), .timeout(to1)
  );

  // Timer disabled, wrapping counter.
  fsm_ring_ctrl #(.TIMEOUT(0), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out2), .state(st2), .dwell(dw2), .count(cn2), .timeout(to2)
  );

  typedef struct {
    int         which;
    logic [1:0] st;
    logic [7:0] dw;
    logic [7:0] cnt;
    logic       to;
    logic [3:0] mask;  // bit0 state/out, bit1 dwell, bit2 count, bit3 timeout
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  event  sample_ev;

  task automatic push(input int which, input int st, input int dw, input int cnt,
                      input logic to, input logic [3:0] mask, input string nm);
    exp_t e;
    e.which = which;
    e.st    = 2'(st);
    e.dw    = 8'(dw);
    e.cnt   = 8'(cnt);
    e.to    = to;
    e.mask  = mask;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_entry(input exp_t e, input string nm);
    logic [3:0] a_out;
    logic [1:0] a_st;
    logic [7:0] a_dw;
    logic [7:0] a_cn;
    logic       a_to;
    logic [3:0] e_out;
    case (e.which)
      1:       begin a_out = out1; a_st = st1; a_dw = dw1; a_cn = cn1; a_to = to1; end
      2:       begin a_out = out2; a_st = st2; a_dw = dw2; a_cn = cn2; a_to = to2; end
      default: begin a_out = out0; a_st = st0; a_dw = dw0; a_cn = cn0; a_to = to0; end
    endcase
    e_out = 4'b0001 << e.st;
    if (e.mask[0]) begin
      checks++;
      if (a_st !== e.st || a_out !== e_out) begin
        errors++;
        $display("FAIL %s dut%0d state: got %0d out %b, expected %0d out %b",
                 nm, e.which, a_st, a_out, e.st, e_out);
      end
    end
    if (e.mask[1]) begin
      checks++;
      if (a_dw !== e.dw) begin
        errors++;
        $display("FAIL %s dut%0d dwell: got %0d, expected %0d", nm, e.which, a_dw, e.dw);
      end
    end
    if (e.mask[2]) begin
      checks++;
      if (a_cn !== e.cnt) begin
        errors++;
        $display("FAIL %s dut%0d count: got %0d, expected %0d", nm, e.which, a_cn, e.cnt);
      end
    end
    if (e.mask[3]) begin
      checks++;
      if (a_to !== e.to) begin
        errors++;
        $display("FAIL %s dut%0d timeout: got %b, expected %b", nm, e.which, a_to, e.to);
      end
    end
  endtask

  // Monitor: after each active edge (or an explicit mid-cycle sample) drain pending expectations.
  initial begin
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        check_entry(exp_q.pop_front(), name_q.pop_front());
      end
    end
  end

  // Apply inputs between edges, expect the result after the next rising edge.
  task automatic step(input logic e_en, input logic [1:0] e_in, input int st, input int dw,
                      input int cnt, input logic to, input string nm);
    en = e_en;
    in = e_in;
    push(0, st, dw, cnt, to, 4'hF, nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_now(input string nm);
    push(0, 1, 0, 0, 1'b0, 4'hF, nm);
    -> sample_ev;
    #2;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    in  = 2'd0;
    repeat (2) @(negedge clk);
    check_now("reset");
    rst = 1'b1;

    for (int i = 1; i <= 3; i++) step(1'b0, 2'd0, 1, 0, i, 1'b0, "idle");

    step(1'b1, 2'd1, 2, 0, 4, 1'b0, "walk_adv");
    step(1'b1, 2'd1, 3, 0, 4, 1'b0, "walk_adv");
    step(1'b1, 2'd1, 0, 0, 4, 1'b0, "walk_adv_wrap");
    step(1'b1, 2'd1, 1, 0, 4, 1'b0, "walk_adv");
    step(1'b1, 2'd2, 0, 0, 5, 1'b0, "walk_ret");
    step(1'b1, 2'd2, 3, 0, 5, 1'b0, "walk_ret_wrap");

    step(1'b1, 2'd2, 2, 0, 5, 1'b0, "to_enter");
    for (int i = 1; i <= 7; i++) step(1'b1, 2'd0, 2, i, 5, 1'b0, "to_dwell");
    step(1'b1, 2'd0, 3, 0, 5, 1'b1, "to_fire");
    step(1'b1, 2'd0, 3, 1, 5, 1'b0, "to_clear");

    step(1'b1, 2'd3, 1, 0, 5, 1'b0, "restart");
    for (int i = 1; i <= 5; i++) step(1'b1, 2'd0, 1, i, 5 + i, 1'b0, "rst_hold");
    step(1'b1, 2'd3, 1, 0, 11, 1'b0, "restart_in_rst");
    step(1'b1, 2'd1, 2, 0, 12, 1'b0, "prio_enter");
    for (int i = 1; i <= 7; i++) step(1'b1, 2'd0, 2, i, 12, 1'b0, "prio_dwell");
    step(1'b1, 2'd2, 1, 0, 12, 1'b0, "cmd_beats_to");

    for (int i = 1; i <= 3; i++) step(1'b1, 2'd0, 1, i, 12 + i, 1'b0, "pre_gate");
    for (int i = 1; i <= 20; i++) step(1'b0, 2'd1, 1, 3, 15 + i, 1'b0, "gated");

    step(1'b1, 2'd1, 2, 0, 36, 1'b0, "mid_adv");
    step(1'b1, 2'd1, 3, 0, 36, 1'b0, "mid_adv");
    for (int i = 1; i <= 5; i++) step(1'b1, 2'd0, 3, i, 36, 1'b0, "mid_dwell");

    rst = 1'b0;
    #1;
    check_now("async_reset");

    // Long stay in the restart state exercises counter saturation and wrap.
    en  = 1'b1;
    in  = 2'd0;
    rst = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 256) push(2, 1, 255, 0, 1'b0, 4'hF, "wrap_256");
      if (i == 300) begin
        push(1, 1, 255, 255, 1'b0, 4'hF, "sat_300");
        push(2, 1, 255, 44, 1'b0, 4'hF, "wrap_300");
      end
      @(posedge clk);
      #2;
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
